// File: rtl/biriscv_divider_iter.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Produces one quotient bit per clock and holds the last result until the next completion.
module biriscv_divider_iter #(
    parameter bit DIV_ZERO_FAST = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [31:0] opcode_i,
    input  logic [31:0] operand_ra_i,
    input  logic [31:0] operand_rb_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        complete_o,
    output logic [31:0] result_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] dividend_q, dividend_d;
    logic [31:0] divisor_q, divisor_d;
    logic [31:0] quotient_q, quotient_d;
    logic [31:0] remainder_q, remainder_d;
    logic [4:0]  count_q, count_d;
    logic        neg_quot_q, neg_quot_d;
    logic        neg_rem_q, neg_rem_d;
    logic        is_rem_q, is_rem_d;
    logic [31:0] result_q, result_d;

    logic        is_div_op;
    logic        is_signed_op;
    logic        is_rem_op;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic        step_ge;
    logic [31:0] rem_step;
    logic [31:0] quot_step;
    logic        unused_bits;

    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    assign is_div_op    = (opcode_i[6:0] == 7'b0110011) && (opcode_i[31:25] == 7'b0000001) && opcode_i[14];
    assign is_signed_op = ~opcode_i[12];
    assign is_rem_op    = opcode_i[13];
    assign unused_bits  = ^{opcode_i[24:15], opcode_i[11:7], diff[32]};

    // One restoring step: the running remainder never exceeds the divisor, so the
    // difference always fits back into 32 bits when the trial subtract succeeds.
    assign shifted   = {remainder_q, dividend_q[31]};
    assign step_ge   = (shifted >= {1'b0, divisor_q});
    assign diff      = shifted - {1'b0, divisor_q};
    assign rem_step  = step_ge ? diff[31:0] : shifted[31:0];
    assign quot_step = {quotient_q[30:0], step_ge};

    always_comb begin
        state_d     = state_q;
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        count_d     = count_q;
        neg_quot_d  = neg_quot_q;
        neg_rem_d   = neg_rem_q;
        is_rem_d    = is_rem_q;
        result_d    = result_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i && is_div_op && !flush_i) begin
                    dividend_d  = cond_neg(operand_ra_i, is_signed_op & operand_ra_i[31]);
                    divisor_d   = cond_neg(operand_rb_i, is_signed_op & operand_rb_i[31]);
                    quotient_d  = 32'd0;
                    remainder_d = 32'd0;
                    count_d     = 5'd31;
                    neg_quot_d  = is_signed_op & (operand_ra_i[31] ^ operand_rb_i[31])
                                  & (operand_rb_i != 32'd0);
                    neg_rem_d   = is_signed_op & operand_ra_i[31];
                    is_rem_d    = is_rem_op;
                    if (DIV_ZERO_FAST && (operand_rb_i == 32'd0)) begin
                        state_d  = ST_DONE;
                        result_d = is_rem_op ? operand_ra_i : 32'hFFFF_FFFF;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                dividend_d  = {dividend_q[30:0], 1'b0};
                quotient_d  = quot_step;
                remainder_d = rem_step;
                count_d     = count_q - 5'd1;
                if (count_q == 5'd0) begin
                    state_d  = ST_DONE;
                    result_d = is_rem_q ? cond_neg(rem_step, neg_rem_q)
                                        : cond_neg(quot_step, neg_quot_q);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort wins over everything, including a start or a final step on this edge.
        if (flush_i) begin
            state_d  = ST_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            dividend_q  <= 32'd0;
            divisor_q   <= 32'd0;
            quotient_q  <= 32'd0;
            remainder_q <= 32'd0;
            count_q     <= 5'd0;
            neg_quot_q  <= 1'b0;
            neg_rem_q   <= 1'b0;
            is_rem_q    <= 1'b0;
            result_q    <= 32'd0;
        end else begin
            state_q     <= state_d;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            count_q     <= count_d;
            neg_quot_q  <= neg_quot_d;
            neg_rem_q   <= neg_rem_d;
            is_rem_q    <= is_rem_d;
            result_q    <= result_d;
        end
    end

    assign busy_o     = (state_q == ST_BUSY);
    assign complete_o = (state_q == ST_DONE);
    assign result_o   = result_q;

endmodule

// File: tb/tb_biriscv_divider_iter.sv
// Bench for biriscv_divider_iter: two instances (fast and slow zero-divide) driven in
// parallel and compared every cycle against an arithmetic reference model.
module tb_biriscv_divider_iter;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] opcode_i = 32'd0;
    logic [31:0] operand_ra_i = 32'd0;
    logic [31:0] operand_rb_i = 32'd0;
    logic        flush_i = 1'b0;

    logic        busy_f, cmp_f, busy_s, cmp_s;
    logic [31:0] res_f, res_s;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    biriscv_divider_iter #(.DIV_ZERO_FAST(1'b1)) u_fast (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .opcode_i(opcode_i),
        .operand_ra_i(operand_ra_i), .operand_rb_i(operand_rb_i), .flush_i(flush_i),
        .busy_o(busy_f), .complete_o(cmp_f), .result_o(res_f)
    );

    biriscv_divider_iter #(.DIV_ZERO_FAST(1'b0)) u_slow (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .opcode_i(opcode_i),
        .operand_ra_i(operand_ra_i), .operand_rb_i(operand_rb_i), .flush_i(flush_i),
        .busy_o(busy_s), .complete_o(cmp_s), .result_o(res_s)
    );

    localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

    function automatic logic [31:0] mk_op(input logic [2:0] f3);
        return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    function automatic logic is_div(input logic [31:0] op);
        return (op[6:0] == 7'b0110011) && (op[31:25] == 7'b0000001) && op[14];
    endfunction

    // Architectural RV32M result from plain arithmetic.
    function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        logic [31:0] q, r;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (!f3[0]) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        return f3[1] ? r : q;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: index 0 = fast zero-divide instance, index 1 = slow.
    logic        m_pend [2];
    int          m_done_at [2];
    logic [31:0] m_res [2];
    logic        e_cmp [2];
    logic [31:0] e_res [2];
    int          m_cyc;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_cyc <= 0;
            for (int i = 0; i < 2; i++) begin
                m_pend[i]    <= 1'b0;
                m_done_at[i] <= 0;
                m_res[i]     <= 32'd0;
                e_cmp[i]     <= 1'b0;
                e_res[i]     <= 32'd0;
            end
        end else begin
            m_cyc <= m_cyc + 1;
            for (int i = 0; i < 2; i++) begin
                e_cmp[i] <= 1'b0;
                if (flush_i) begin
                    m_pend[i] <= 1'b0;
                end else if (m_pend[i] && m_cyc == m_done_at[i]) begin
                    m_pend[i] <= 1'b0;
                    e_cmp[i]  <= 1'b1;
                    e_res[i]  <= m_res[i];
                end else if (!m_pend[i] && !e_cmp[i] && start_i && is_div(opcode_i)) begin
                    if (i == 0 && operand_rb_i == 32'd0) begin
                        e_cmp[i] <= 1'b1;
                        e_res[i] <= ref_div(opcode_i[14:12], operand_ra_i, operand_rb_i);
                    end else begin
                        m_pend[i]    <= 1'b1;
                        m_done_at[i] <= m_cyc + 32;
                        m_res[i]     <= ref_div(opcode_i[14:12], operand_ra_i, operand_rb_i);
                    end
                end
            end
        end
    end

    always @(negedge clk_i) begin
        chk("busy_fast", {31'd0, busy_f}, {31'd0, m_pend[0]});
        chk("complete_fast", {31'd0, cmp_f}, {31'd0, e_cmp[0]});
        chk("result_fast", res_f, e_res[0]);
        chk("busy_slow", {31'd0, busy_s}, {31'd0, m_pend[1]});
        chk("complete_slow", {31'd0, cmp_s}, {31'd0, e_cmp[1]});
        chk("result_slow", res_s, e_res[1]);
    end

    // Issue one op and pin its result and latency to hand-computed literals.
    task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_kf, input int exp_ks);
        int kf, ks, busy_cnt;
        logic [31:0] rf, rs;
        kf = -1; ks = -1; busy_cnt = 0; rf = 32'd0; rs = 32'd0;
        opcode_i = mk_op(f3); operand_ra_i = a; operand_rb_i = b; start_i = 1'b1;
        for (int k = 0; k <= 40; k++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            if (busy_f) busy_cnt++;
            if (cmp_f && kf < 0) begin kf = k; rf = res_f; end
            if (cmp_s && ks < 0) begin ks = k; rs = res_s; end
            if (kf >= 0 && ks >= 0) break;
        end
        chk({nm, "_lat_fast"}, kf, exp_kf);
        chk({nm, "_lat_slow"}, ks, exp_ks);
        chk({nm, "_res_fast"}, rf, exp_res);
        chk({nm, "_res_slow"}, rs, exp_res);
        chk({nm, "_busy_cycles"}, busy_cnt, exp_kf);
        @(negedge clk_i);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom % 6)
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom % 16;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int seen;
        logic [2:0] f3;
        logic [9:0] regs;
        repeat (2) @(negedge clk_i);
        chk("reset_busy", {31'd0, busy_f}, 32'd0);
        chk("reset_complete", {31'd0, cmp_f}, 32'd0);
        chk("reset_result", res_f, 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        run_op("divu_100_7", F_DIVU, 32'd100, 32'd7, 32'd14, 32, 32);
        run_op("rem_m7_2", F_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32, 32);
        run_op("div_m7_2", F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32, 32);
        run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32, 32);
        run_op("rem_ovf", F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32, 32);
        run_op("div_5_0", F_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, 32);
        run_op("remu_x_0", F_REMU, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, 0, 32);

        // Flush mid-operation: no completion, result holds.
        opcode_i = mk_op(F_DIVU); operand_ra_i = 32'd100; operand_rb_i = 32'd7; start_i = 1'b1;
        @(negedge clk_i); start_i = 1'b0;
        repeat (9) @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i); flush_i = 1'b0;
        chk("flush_busy", {31'd0, busy_f}, 32'd0);
        seen = 0;
        for (int k = 0; k < 35; k++) begin
            @(negedge clk_i);
            if (cmp_f || cmp_s) seen++;
        end
        chk("flush_no_complete", seen, 0);
        chk("flush_result_hold", res_f, 32'hDEAD_BEEF);
        run_op("divu_9_3", F_DIVU, 32'd9, 32'd3, 32'd3, 32, 32);

        // Start and flush together: start dropped.
        opcode_i = mk_op(F_DIVU); operand_ra_i = 32'd50; operand_rb_i = 32'd5;
        start_i = 1'b1; flush_i = 1'b1;
        @(negedge clk_i); start_i = 1'b0; flush_i = 1'b0;
        chk("start_flush_busy_f", {31'd0, busy_f}, 32'd0);
        chk("start_flush_busy_s", {31'd0, busy_s}, 32'd0);

        // Asynchronous reset mid-operation.
        opcode_i = mk_op(F_DIVU); operand_ra_i = 32'd1000; operand_rb_i = 32'd3; start_i = 1'b1;
        @(negedge clk_i); start_i = 1'b0;
        repeat (14) @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        chk("async_rst_busy", {31'd0, busy_f}, 32'd0);
        chk("async_rst_result", res_f, 32'd0);
        chk("async_rst_result_s", res_s, 32'd0);
        @(negedge clk_i);
        #2 rst_ni = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_i);
            if (cmp_f || cmp_s) seen++;
        end
        chk("rst_no_complete", seen, 0);

        // Non-divide opcode (ADD) is ignored.
        opcode_i = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
        operand_ra_i = 32'd1; operand_rb_i = 32'd2; start_i = 1'b1;
        @(negedge clk_i); start_i = 1'b0;
        chk("add_no_busy", {31'd0, busy_f}, 32'd0);
        chk("add_no_complete", {31'd0, cmp_f}, 32'd0);

        // Random traffic; starts while busy/done and stray flushes are exercised too.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk_i);
            f3 = 3'($urandom);
            regs = 10'($urandom);
            if ($urandom % 8 == 0)
                opcode_i = {7'($urandom % 2 == 0 ? 0 : 32), regs, f3, 5'd3, 7'b0110011};
            else
                opcode_i = {7'b0000001, regs, 1'b1, f3[1:0], 5'd3, 7'b0110011};
            operand_ra_i = pick_operand();
            operand_rb_i = pick_operand();
            start_i = ($urandom % 4 == 0);
            flush_i = ($urandom % 60 == 0);
        end
        @(negedge clk_i);
        start_i = 1'b0; flush_i = 1'b0;
        repeat (40) @(negedge clk_i);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
